// File: rtl/fb_pkg.sv
// Shared parameters and controller state encoding for the double-buffered
// frame-buffer arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 11;
  localparam int FB_DATA_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_COPY_RD,
    ST_COPY_WAIT,
    ST_COPY_WR,
    ST_DONE
  } fb_state_t;

endpackage

// File: rtl/fb_arbiter.sv
// Arbitrates one single-port bank RAM between the display scan (never stalled),
// a pixel writer on the back bank, and a frame-synchronous swap with optional copy-back.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              swap_req,
  input  logic              copy_en,
  input  logic              frame_end,
  output logic              swap_done,
  output logic              front_bank,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  fb_state_t         state_reg;
  logic              front_reg;
  logic              copy_en_reg;
  logic [ADDR_W-1:0] copy_addr_reg;
  logic [DATA_W-1:0] copy_buf_reg;
  logic              disp_valid_reg;
  logic              wr_grant;

  assign wr_grant   = wr_req && !disp_req &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_PEND));
  assign wr_ack     = wr_grant && !rst;
  assign swap_done  = (state_reg == ST_DONE);
  assign front_bank = front_reg;
  assign disp_valid = disp_valid_reg;
  assign disp_data  = mem_rdata;

  // The RAM strobes are gated by rst so an abort mid-copy cannot land a write.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (disp_req) begin
        mem_addr = {front_reg, disp_addr};
      end else if (wr_grant) begin
        mem_we    = 1'b1;
        mem_addr  = {~front_reg, wr_addr};
        mem_wdata = wr_data;
      end else if (state_reg == ST_COPY_RD) begin
        mem_addr = {front_reg, copy_addr_reg};
      end else if (state_reg == ST_COPY_WR) begin
        mem_we    = 1'b1;
        mem_addr  = {~front_reg, copy_addr_reg};
        mem_wdata = copy_buf_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      front_reg      <= 1'b0;
      copy_en_reg    <= 1'b0;
      copy_addr_reg  <= '0;
      copy_buf_reg   <= '0;
      disp_valid_reg <= 1'b0;
    end else begin
      disp_valid_reg <= disp_req;
      case (state_reg)
        ST_IDLE: begin
          if (swap_req) begin
            copy_en_reg <= copy_en;
            state_reg   <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (frame_end) begin
            front_reg     <= ~front_reg;
            copy_addr_reg <= '0;
            state_reg     <= copy_en_reg ? ST_COPY_RD : ST_DONE;
          end
        end
        ST_COPY_RD: begin
          if (!disp_req) state_reg <= ST_COPY_WAIT;
        end
        ST_COPY_WAIT: begin
          copy_buf_reg <= mem_rdata;
          state_reg    <= ST_COPY_WR;
        end
        ST_COPY_WR: begin
          if (!disp_req) begin
            copy_addr_reg <= copy_addr_reg + 1'b1;
            state_reg     <= (copy_addr_reg == '1) ? ST_DONE : ST_COPY_RD;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, pixel address width (64x32 panel).
REQ-002 SHALL have parameter DATA_W, default 24, pixel word width (RGB888).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port disp_req  in  1  display read request, never stalled.
REQ-006 SHALL have port disp_addr  in  ADDR_W  display pixel address.
REQ-007 SHALL have ports disp_data  out  DATA_W  and disp_valid  out  1  read data and its qualifier.
REQ-008 SHALL have ports wr_req  in  1, wr_addr  in  ADDR_W, wr_data  in  DATA_W  writer request, address and data.
REQ-009 SHALL have port wr_ack  out  1  write-accepted strobe.
REQ-010 SHALL have ports swap_req  in  1  and copy_en  in  1  swap request, and copy-back enable sampled with it.
REQ-011 SHALL have port frame_end  in  1  one-cycle pulse from the scan controller at frame completion.
REQ-012 SHALL have ports swap_done  out  1  and front_bank  out  1  swap-complete pulse and displayed bank.
REQ-013 SHALL have ports mem_addr  out  ADDR_W+1, mem_we  out  1, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W  single-port sync RAM, 1-cycle read latency, bank = MSB.

Function
REQ-014 SHALL grant the memory to the display whenever disp_req=1: mem_addr={front_bank,disp_addr}, mem_we=0.
REQ-015 SHALL assert disp_valid exactly one cycle after a display grant, with disp_data=mem_rdata in that cycle.
REQ-016 SHALL, in states IDLE and PEND with disp_req=0 and wr_req=1, write {~front_bank,wr_addr}, and assert wr_ack in the same cycle.
REQ-017 SHALL hold wr_ack=0 whenever the writer is not granted; the writer holds request fields until ack.
REQ-018 SHALL implement states IDLE, PEND, COPY_RD, COPY_WAIT, COPY_WR, DONE.
REQ-019 SHALL move IDLE->PEND on swap_req=1, latching copy_en; swap_req outside IDLE is ignored.
REQ-020 SHALL, in PEND on frame_end=1, toggle front_bank at the next edge, clear copy_addr, and go to COPY_RD if latched copy_en=1, else DONE.
REQ-021 SHALL treat swap_req and frame_end in the same IDLE cycle as swap request only; the swap waits for the next frame_end.
REQ-022 SHALL direct a write granted in the frame_end cycle to the pre-swap back bank.
REQ-023 SHALL, in COPY_RD with disp_req=0, read {front_bank,copy_addr} and go to COPY_WAIT; with disp_req=1, remain.
REQ-024 SHALL, in COPY_WAIT, capture mem_rdata into a copy buffer, go to COPY_WR, and issue no memory access.
REQ-025 SHALL, in COPY_WR with disp_req=0, write the buffer to {~front_bank,copy_addr}, increment copy_addr, go to COPY_RD, or DONE when copy_addr=2^ADDR_W-1; with disp_req=1, remain.
REQ-026 SHALL not ack writer requests in any COPY state.
REQ-027 SHALL pulse swap_done for the single DONE cycle, then return to IDLE.
REQ-028 SHALL ignore frame_end outside PEND.
REQ-029 SHALL drive mem_we=0 and mem_addr=0 when no access is granted.

Reset
REQ-030 SHALL on rst=1 force state IDLE, front_bank=0, copy_addr=0, buffer=0, latched copy_en=0.
REQ-031 SHALL on rst=1 force disp_valid, wr_ack, swap_done, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL abort any pending swap or copy on rst mid-operation, with no further memory writes.

Structure
REQ-033 SHALL take ADDR_W, DATA_W defaults and state encoding from shared package fb_pkg.
REQ-034 SHALL be a single module without sub-modules; bank RAM is external.

Verification
REQ-035 SHALL cover: disp_req=1 and wr_req=1 in the same cycle, addr 5 -> display read at {0,5}, wr_ack=0, disp_valid=1 next cycle.
REQ-036 SHALL cover: wr_req=1, wr_addr=10, data 0xFF0000, disp_req=0 -> mem_we=1, mem_addr={1,10}, wr_ack=1 same cycle.
REQ-037 SHALL cover: swap_req with copy_en=0, frame_end 20 cycles later -> front_bank=1 after that edge, swap_done pulse one cycle later.
REQ-038 SHALL cover: swap_req with copy_en=1, ADDR_W=3, display requesting every other cycle -> all 8 words copied bank1->bank0, writer unacked until swap_done.
REQ-039 SHALL cover: swap_req and frame_end in the same cycle -> no swap until the next frame_end.
REQ-040 SHALL cover: rst asserted in COPY_WR -> state IDLE, front_bank=0, mem_we=0 immediately.
